// File: rtl/acia_ctrl_if.sv
// Register-bus and streaming handshake bundle for the ACIA sequencer.
// master = sequencer side; slave = ACIA device, TX requesters and RX consumer.
interface acia_ctrl_if;
  logic       acia_cs;
  logic       acia_we;
  logic       acia_rs;
  logic [7:0] acia_din;
  logic [7:0] acia_dout;
  logic [7:0] tx0_data;
  logic       tx0_valid;
  logic       tx0_ready;
  logic [7:0] tx1_data;
  logic       tx1_valid;
  logic       tx1_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       init_done;

  modport master (
    output acia_cs, acia_we, acia_rs, acia_din, tx0_ready, tx1_ready,
           rx_data, rx_valid, init_done,
    input  acia_dout, tx0_data, tx0_valid, tx1_data, tx1_valid, rx_ready
  );

  modport slave (
    input  acia_cs, acia_we, acia_rs, acia_din, tx0_ready, tx1_ready,
           rx_data, rx_valid, init_done,
    output acia_dout, tx0_data, tx0_valid, tx1_data, tx1_valid, rx_ready
  );
endinterface

// File: rtl/acia_ctrl.sv
// Polling sequencer owning the ACIA register bus: init, status polling,
// round-robin TX from two requesters, single-entry RX buffer.
module acia_ctrl #(
  parameter logic [7:0] CFG = 8'h14
) (
  input logic       clk,
  input logic       rst,
  acia_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    BOOT, INIT_RST, INIT_CFG, POLL_RD, POLL_WAIT, RX_RD, RX_WAIT, TX_WR
  } state_t;

  state_t     state, nxt;
  logic       last_grant, grant, sel;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, init_done_q;

  // divide select 2'b11 is the master-reset code, never a usable config
  if (CFG[1:0] == 2'b11) begin : g_cfg_check
    $error("acia_ctrl: CFG[1:0] must not be 2'b11");
  end

  assign sel = (bus.tx0_valid & bus.tx1_valid) ? ~last_grant : bus.tx1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == POLL_WAIT && nxt == TX_WR) grant <= sel;
      if (state == TX_WR) last_grant <= grant;
      if (nxt == POLL_RD) init_done_q <= 1'b1;
      // load only happens with the buffer empty, so it never meets a clear
      if (state == RX_WAIT) begin
        rx_data_q  <= bus.acia_dout;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    nxt           = state;
    bus.acia_cs   = 1'b0;
    bus.acia_we   = 1'b0;
    bus.acia_rs   = 1'b0;
    bus.acia_din  = 8'h00;
    bus.tx0_ready = 1'b0;
    bus.tx1_ready = 1'b0;
    case (state)
      BOOT:     nxt = INIT_RST;
      INIT_RST: begin
        bus.acia_cs = 1'b1; bus.acia_we = 1'b1; bus.acia_din = 8'h03;
        nxt = INIT_CFG;
      end
      INIT_CFG: begin
        bus.acia_cs = 1'b1; bus.acia_we = 1'b1; bus.acia_din = CFG;
        nxt = POLL_RD;
      end
      POLL_RD: begin
        bus.acia_cs = 1'b1;
        nxt = POLL_WAIT;
      end
      POLL_WAIT: begin
        // RX outranks TX so a waiting byte is pulled before the ACIA overruns
        if (bus.acia_dout[0] && !rx_valid_q)                          nxt = RX_RD;
        else if (bus.acia_dout[1] && (bus.tx0_valid || bus.tx1_valid)) nxt = TX_WR;
        else                                                           nxt = POLL_RD;
      end
      RX_RD: begin
        bus.acia_cs = 1'b1; bus.acia_rs = 1'b1;
        nxt = RX_WAIT;
      end
      RX_WAIT:  nxt = POLL_RD;
      TX_WR: begin
        bus.acia_cs   = 1'b1; bus.acia_we = 1'b1; bus.acia_rs = 1'b1;
        bus.acia_din  = grant ? bus.tx1_data : bus.tx0_data;
        bus.tx0_ready = ~grant;
        bus.tx1_ready = grant;
        nxt = POLL_RD;
      end
      default:  nxt = BOOT;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_acia_ctrl.sv
// Randomized scoreboard bench: behavioural ACIA device, two TX producers,
// RX consumer, and a monitor checking bus ops against the polling rules.
module tb_acia_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acia_ctrl_if ifc ();
  acia_ctrl #(.CFG(8'h14)) dut (.clk(clk), .rst(rst), .bus(ifc));

  localparam int IDLE = 0, SRD = 1, DRD = 2, DWR = 3, CWR = 4;

  int checks = 0, errors = 0;
  logic [7:0] td [2];
  logic [1:0] tv;
  logic [1:0] rdy;
  logic [7:0] txq [2][$];
  logic [7:0] rx_q [$];
  logic [7:0] ctl_q [$];
  int         gq [$];
  int         drd_cnt = 0;
  logic       rx_hold, rx_en, txe_stuck;

  assign ifc.tx0_data  = td[0];
  assign ifc.tx1_data  = td[1];
  assign ifc.tx0_valid = tv[0];
  assign ifc.tx1_valid = tv[1];
  assign rdy = {ifc.tx1_ready, ifc.tx0_ready};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bus_op();
    if (!ifc.acia_cs) return IDLE;
    if (!ifc.acia_we) return ifc.acia_rs ? DRD : SRD;
    return ifc.acia_rs ? DWR : CWR;
  endfunction

  // ACIA device: no overrun (a new byte only arrives while rxf is clear),
  // txe drops on each data write and returns after a random busy time
  logic       a_rxf = 1'b0, a_txe = 1'b1;
  logic [7:0] a_rxb = 8'h00, rx_seed = 8'h5A;
  int         a_busy = 0;
  always @(posedge clk) begin
    if (ifc.acia_cs && !ifc.acia_we)
      ifc.acia_dout <= ifc.acia_rs ? a_rxb : {6'b0, a_txe, a_rxf};
    if (ifc.acia_cs && ifc.acia_we && !ifc.acia_rs && ifc.acia_din == 8'h03) begin
      a_rxf <= 1'b0; a_txe <= 1'b1; a_busy <= 0;
      rx_q.delete();
    end else begin
      if (ifc.acia_cs && ifc.acia_we && ifc.acia_rs && !txe_stuck) begin
        a_txe <= 1'b0; a_busy <= $urandom_range(1, 6);
      end else if (a_busy != 0) begin
        a_busy <= a_busy - 1;
        if (a_busy == 1) a_txe <= 1'b1;
      end
      if (ifc.acia_cs && !ifc.acia_we && ifc.acia_rs) begin
        a_rxf <= 1'b0;
      end else if (!a_rxf && rx_en && $urandom_range(0, 3) == 0) begin
        a_rxb <= rx_seed; a_rxf <= 1'b1;
        rx_q.push_back(rx_seed);
        rx_seed <= 8'($urandom);
      end
    end
  end

  initial ifc.acia_dout = 8'h00;

  initial forever begin
    @(posedge clk); #1;
    ifc.rx_ready = rx_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // monitor / scoreboard
  initial begin
    int exp_op, op, g;
    logic prev_srd, mon_last;
    exp_op = -1; prev_srd = 1'b0; mon_last = 1'b1;
    forever begin
      @(negedge clk);
      op = bus_op();
      if (rst) begin
        exp_op = -1; prev_srd = 1'b0; mon_last = 1'b1;
      end else begin
        if (exp_op >= 0) chk("poll_decision", op, exp_op);
        exp_op = -1;
        if (prev_srd) begin
          chk("poll_wait_idle", op, IDLE);
          if (ifc.acia_dout[0] && !ifc.rx_valid)           exp_op = DRD;
          else if (ifc.acia_dout[1] && (tv != 2'b00))       exp_op = DWR;
          else                                              exp_op = SRD;
        end
        prev_srd = (op == SRD);
        if (op != DWR) chk("ready_outside_write", rdy, 0);
        case (op)
          CWR: begin
            chk("ctl_write_init_done", ifc.init_done, 0);
            if (ctl_q.size() == 0) chk("ctl_write_unexpected", ifc.acia_din, -1);
            else chk("ctl_write_din", ifc.acia_din, ctl_q.pop_front());
          end
          SRD: chk("status_read_init_done", ifc.init_done, 1);
          DRD: begin
            chk("rx_read_while_full", ifc.rx_valid, 0);
            drd_cnt++;
          end
          DWR: begin
            chk("one_ready", int'(rdy[0]) + int'(rdy[1]), 1);
            g = rdy[1] ? 1 : 0;
            chk("ready_with_valid", tv[g], 1);
            if (tv == 2'b11) chk("round_robin", g, mon_last ? 0 : 1);
            mon_last = g[0];
            gq.push_back(g);
            if (txq[g].size() == 0) chk("tx_unexpected", ifc.acia_din, -1);
            else chk("tx_data", ifc.acia_din, txq[g].pop_front());
          end
          default: ;
        endcase
        if (ifc.rx_valid && ifc.rx_ready) begin
          if (rx_q.size() == 0) chk("rx_unexpected", ifc.rx_data, -1);
          else chk("rx_data", ifc.rx_data, rx_q.pop_front());
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tx_send(input int i, input logic [7:0] d);
    int n;
    td[i] = d; tv[i] = 1'b1;
    txq[i].push_back(d);
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (rdy[i]) break;
    end
    if (n == 2000) chk("tx_accept_timeout", 0, 1);
    @(posedge clk); #1;
    tv[i] = 1'b0;
  endtask

  task automatic producer(input int i, input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      tx_send(i, 8'($urandom));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ctl_q.delete(); ctl_q.push_back(8'h03); ctl_q.push_back(8'h14);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && !ifc.rx_valid && txq[0].size() == 0 && txq[1].size() == 0) break;
    end
    chk("drain_complete", (n < 3000) ? 1 : 0, 1);
  endtask

  initial begin
    int n, d0;
    rst = 1'b1; tv = 2'b00; td[0] = 8'h00; td[1] = 8'h00;
    rx_hold = 1'b1; rx_en = 1'b0; txe_stuck = 1'b0;
    ctl_q.push_back(8'h03); ctl_q.push_back(8'h14);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", {ifc.acia_cs, ifc.acia_we, ifc.acia_rs, ifc.acia_din}, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_rx_valid", ifc.rx_valid, 0);
    chk("rst_init_done", ifc.init_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("init_boot", {ifc.acia_cs, ifc.acia_we, ifc.acia_rs, ifc.acia_din}, 0);
    @(negedge clk);
    chk("init_master_reset", {ifc.acia_cs, ifc.acia_we, ifc.acia_rs, ifc.acia_din}, {3'b110, 8'h03});
    @(negedge clk);
    chk("init_config", {ifc.acia_cs, ifc.acia_we, ifc.acia_rs, ifc.acia_din}, {3'b110, 8'h14});
    @(negedge clk);
    chk("init_first_poll", {ifc.acia_cs, ifc.acia_we, ifc.acia_rs}, 3'b100);
    chk("init_done_rise", ifc.init_done, 1);

    // single TX byte
    rx_hold = 1'b0;
    @(posedge clk); #1;
    tx_send(0, 8'hA5);
    drain();

    // mixed random traffic
    rx_en = 1'b1;
    fork
      producer(0, 40, 6);
      producer(1, 40, 6);
    join
    rx_en = 1'b0;
    drain();

    // RX backpressure: full buffer blocks further data reads
    rx_hold = 1'b1; rx_en = 1'b1;
    for (n = 0; n < 500; n++) begin @(negedge clk); if (ifc.rx_valid) break; end
    chk("bp_rx_loaded", ifc.rx_valid, 1);
    d0 = drd_cnt;
    repeat (40) @(negedge clk);
    chk("bp_no_reads_while_full", drd_cnt - d0, 0);
    chk("bp_rx_still_valid", ifc.rx_valid, 1);
    rx_hold = 1'b0;
    for (n = 0; n < 500; n++) begin @(negedge clk); if (drd_cnt != d0) break; end
    chk("bp_read_after_release", (drd_cnt != d0) ? 1 : 0, 1);
    rx_en = 1'b0;
    drain();

    // round robin from reset, txe held high
    gq.delete(); txe_stuck = 1'b1;
    do_reset();
    fork
      producer(0, 8, 0);
      producer(1, 8, 0);
    join
    chk("rr_count", gq.size(), 16);
    for (int k = 0; k < gq.size(); k++) chk("rr_order", gq[k], k % 2);
    txe_stuck = 1'b0;
    drain();

    // reset landing on a TX write
    rx_en = 1'b1;
    fork
      producer(0, 15, 3);
      producer(1, 15, 3);
      begin
        for (n = 0; n < 2000; n++) begin @(negedge clk); if (bus_op() == DWR) break; end
        chk("midrst_found_write", (n < 2000) ? 1 : 0, 1);
        #1 rst = 1'b1;
        ctl_q.delete(); ctl_q.push_back(8'h03); ctl_q.push_back(8'h14);
        @(negedge clk);
        chk("midrst_bus", {ifc.acia_cs, ifc.acia_we, ifc.acia_rs, ifc.acia_din}, 0);
        chk("midrst_ready", rdy, 0);
        chk("midrst_rx_valid", ifc.rx_valid, 0);
        chk("midrst_init_done", ifc.init_done, 0);
        @(posedge clk); #1 rst = 1'b0;
      end
    join
    rx_en = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acia_ctrl.md
Name: acia_ctrl

Overview:
Polling sequencer that owns the ACIA register bus (cs/we/rs/din/dout) and replaces CPU-driven access for streaming use.
- After reset it programs the ACIA: master reset, then configuration.
- It then polls the status register continuously.
- TX: drains two valid/ready byte requesters through a round-robin arbiter.
- RX: delivers received bytes on a single-entry valid/ready output.

Parameters:
CFG, 8'h14, control byte written after master reset: {rie, tx_ctl[1:0], word[2:0], div[1:0]}. div must not be 2'b11 (elaboration error).

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
acia_cs  output  1  ACIA chip select
acia_we  output  1  ACIA write enable
acia_rs  output  1  ACIA register select (0 = control/status, 1 = data)
acia_din  output  8  ACIA write data
acia_dout  input  8  ACIA read data; registered, valid the cycle after the read strobe
tx0_data  input  8  requester 0 byte
tx0_valid  input  1  requester 0 has byte
tx0_ready  output  1  requester 0 byte accepted
tx1_data  input  8  requester 1 byte
tx1_valid  input  1  requester 1 has byte
tx1_ready  output  1  requester 1 byte accepted
rx_data  output  8  received byte
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ready  input  1  consumer accepts rx_data
init_done  output  1  ACIA configured, polling active

Behaviour:
- Reset (synchronous, active-high on clk):
  - state = BOOT; last_grant = 1 (so requester 0 wins first); rx_valid = 0; rx_data = 0; init_done = 0.
  - Bus outputs all 0; tx0_ready = tx1_ready = 0.
- Bus outputs are decoded from the registered state. In any state not listed below, cs = we = rs = 0 and din = 0.
- States and transitions:
  - BOOT: bus idle -> INIT_RST.
  - INIT_RST: cs=1, we=1, rs=0, din=8'h03 (ACIA master reset) -> INIT_CFG.
  - INIT_CFG: cs=1, we=1, rs=0, din=CFG -> POLL_RD.
  - POLL_RD: cs=1, we=0, rs=0 (status read). init_done = 1 from the first POLL_RD onward until reset -> POLL_WAIT.
  - POLL_WAIT: bus idle; acia_dout = status (bit0 rxf, bit1 txe). Decision, in priority order:
    - rxf & ~rx_valid -> RX_RD.
    - else txe & (tx0_valid | tx1_valid) -> TX_WR; grant latched here.
    - else -> POLL_RD.
  - RX_RD: cs=1, we=0, rs=1 -> RX_WAIT.
  - RX_WAIT: bus idle; rx_data <= acia_dout; rx_valid <= 1 -> POLL_RD.
  - TX_WR: cs=1, we=1, rs=1, din = granted txN_data; txN_ready = 1 for exactly this cycle; last_grant <= granted -> POLL_RD.
- Arbitration:
  - Both valid: grant = ~last_grant (strict alternation).
  - One valid: that requester is granted.
- TX handshake rules:
  - Requester must hold valid and data stable until ready.
  - Only one ready is asserted per TX_WR; a byte transfers exactly when txN_valid & txN_ready.
- RX buffer:
  - rx_valid clears on rx_valid & rx_ready.
  - Clear and load never coincide, because RX_WAIT is entered only when rx_valid = 0.
  - While rx_valid = 1, the ACIA RX is not read; the byte stays in the ACIA, and further arrivals raise its overrun flag. No local drop.
- Throughput:
  - Minimum TX loop is POLL_RD -> POLL_WAIT -> TX_WR (3 cycles per byte); the ACIA's txe gates the real rate.
  - The first POLL_RD after TX_WR sees txe = 0.
- RX priority: RX strictly outranks TX in the same POLL_WAIT.
- Reset mid-operation: returns to BOOT the next edge regardless of state. An in-flight rx_data is discarded, and the full init sequence repeats.

Test Plan:
- Init: release rst -> BOOT for 1 cycle, then a write of 8'h03 to rs=0, then a write of CFG (8'h14) to rs=0, then status reads begin; init_done rises with the first POLL_RD.
- Single TX: model status = 8'h02, tx0_valid with data 8'hA5 -> one data write (cs=1, we=1, rs=1, din=8'hA5) with tx0_ready high that same single cycle; next status 8'h00 -> no write until txe returns.
- Round-robin: tx0 and tx1 both continuously valid, txe always 1 -> writes alternate tx0, tx1, tx0, tx1 (first is tx0); each ready is one cycle long.
- RX with backpressure:
  - status 8'h01 and data 8'h3C -> rx_valid = 1, rx_data = 8'h3C.
  - Hold rx_ready = 0 with rxf = 1 -> no further rs=1 reads.
  - Pulse rx_ready -> rx_valid clears, then the next read occurs.
- Priority: status 8'h03 with tx0_valid = 1 and rx buffer empty -> RX read first; TX write follows on a later poll.
- Mid-op reset: assert rst during TX_WR -> next cycle all bus outputs 0, tx0_ready = 0, rx_valid = 0; the init sequence replays after release.
